// File: rtl/button_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_pkg: shared press-FSM state encoding, default timing constants.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package button_pkg;

    localparam int unsigned c_default_debounce_cycles = 1000000;
    localparam int unsigned c_default_repeat_delay    = 50000000;
    localparam int unsigned c_default_repeat_period   = 20000000;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HELD      = 2'd1,
        REPEATING = 2'd2
    } press_state_e;

    // Counter width for a terminal count of n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_conditioner_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_conditioner_if: raw board inputs and conditioned event outputs.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface button_conditioner_if;

    logic pushButton;
    logic slideSwitch;
    logic countPulse;
    logic buttonLevel;
    logic switchLevel;
    logic repeatActive;

    modport master (
        output pushButton,
        output slideSwitch,
        input  countPulse,
        input  buttonLevel,
        input  switchLevel,
        input  repeatActive
    );

    modport slave (
        input  pushButton,
        input  slideSwitch,
        output countPulse,
        output buttonLevel,
        output switchLevel,
        output repeatActive
    );

endinterface : button_conditioner_if
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_filter: 2-flop synchroniser followed by a persistence filter.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module debounce_filter
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_default_debounce_cycles
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level_out
);

    localparam int unsigned      c_cw   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cw-1:0]  c_last = c_cw'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cw-1:0]  c_one  = c_cw'(1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic [c_cw-1:0] count_q;
    logic [c_cw-1:0] count_d;

    // Any cycle of agreement restarts the persistence count from zero.
    always_comb begin
        stable_d = stable_q;
        count_d  = '0;
        if (sync2_q != stable_q) begin
            if (count_q == c_last) begin
                stable_d = sync2_q;
            end else begin
                count_d = count_q + c_one;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            count_q  <= count_d;
        end
    end

    assign level_out = stable_q;

endmodule : debounce_filter
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_conditioner: debounced button/switch with press and auto-repeat   |
// | count pulses. Revision: 1.0                                              |
// +--------------------------------------------------------------------------+
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_default_debounce_cycles,
    parameter int unsigned REPEAT_DELAY    = c_default_repeat_delay,
    parameter int unsigned REPEAT_PERIOD   = c_default_repeat_period
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    localparam int unsigned c_dw = cnt_width(REPEAT_DELAY);
    localparam int unsigned c_pw = cnt_width(REPEAT_PERIOD);
    localparam int unsigned c_tw = (c_dw > c_pw) ? c_dw : c_pw;

    localparam logic [c_tw-1:0] c_delay_last  = c_tw'(REPEAT_DELAY - 1);
    localparam logic [c_tw-1:0] c_period_last = c_tw'(REPEAT_PERIOD - 1);
    localparam logic [c_tw-1:0] c_one         = c_tw'(1);

    logic            button_level;
    logic            switch_level;
    logic            level_prev_q;
    logic            w_rise;
    press_state_e    state_q;
    press_state_e    state_d;
    logic [c_tw-1:0] timer_q;
    logic [c_tw-1:0] timer_d;
    logic            pulse_q;
    logic            pulse_d;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_filter (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (bus.pushButton),
        .level_out (button_level)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_switch_filter (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (bus.slideSwitch),
        .level_out (switch_level)
    );

    // The previous level keeps tracking while the switch is up, so a button
    // still held when the clear drops does not look like a fresh press.
    assign w_rise = button_level & ~level_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RELEASED;
            timer_q      <= '0;
            pulse_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pulse_q      <= pulse_d;
            level_prev_q <= button_level;
        end
    end

    // Release is tested before terminal count so it always wins.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (switch_level) begin
            state_d = RELEASED;
            timer_d = '0;
        end else begin
            case (state_q)
                RELEASED: begin
                    timer_d = '0;
                    if (w_rise) state_d = HELD;
                end
                HELD: begin
                    if (!button_level) begin
                        state_d = RELEASED;
                        timer_d = '0;
                    end else if (timer_q == c_delay_last) begin
                        state_d = REPEATING;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + c_one;
                    end
                end
                REPEATING: begin
                    if (!button_level) begin
                        state_d = RELEASED;
                        timer_d = '0;
                    end else if (timer_q == c_period_last) begin
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + c_one;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        pulse_d = 1'b0;
        if (!switch_level) begin
            case (state_q)
                RELEASED:  pulse_d = w_rise;
                HELD:      pulse_d = button_level && (timer_q == c_delay_last);
                REPEATING: pulse_d = button_level && (timer_q == c_period_last);
                default:   pulse_d = 1'b0;
            endcase
        end
    end

    assign bus.countPulse   = pulse_q & ~switch_level;
    assign bus.buttonLevel  = button_level;
    assign bus.switchLevel  = switch_level;
    assign bus.repeatActive = (state_q == REPEATING);

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_button_conditioner: directed checks of debounce, press, repeat, clear |
// | and asynchronous reset. Revision: 1.0                                    |
// +--------------------------------------------------------------------------+
module tb_button_conditioner;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   pulse_cnt;
    bit   ra_seen;
    int   p0;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.countPulse === 1'b1) pulse_cnt++;
        if (bus.repeatActive === 1'b1) ra_seen = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        pulse_cnt       = 0;
        ra_seen         = 1'b0;
        reset           = 1'b1;
        bus.pushButton  = 1'b0;
        bus.slideSwitch = 1'b0;
        step(2);
        check_val("rst_cp", 32'(bus.countPulse), 0);
        check_val("rst_bl", 32'(bus.buttonLevel), 0);
        check_val("rst_sl", 32'(bus.switchLevel), 0);
        check_val("rst_ra", 32'(bus.repeatActive), 0);
        reset = 1'b0;
        step(2);

        // Clean press held 8 cycles.
        p0 = pulse_cnt;
        ra_seen = 1'b0;
        bus.pushButton = 1'b1;
        step(5);
        check_val("s1_bl_early", 32'(bus.buttonLevel), 0);
        step(1);
        check_val("s1_bl_rise", 32'(bus.buttonLevel), 1);
        check_val("s1_cp_at_rise", 32'(bus.countPulse), 0);
        step(1);
        check_val("s1_cp", 32'(bus.countPulse), 1);
        step(1);
        check_val("s1_cp_after", 32'(bus.countPulse), 0);
        bus.pushButton = 1'b0;
        step(12);
        check_val("s1_bl_fall", 32'(bus.buttonLevel), 0);
        check_val("s1_npulse", 32'(pulse_cnt - p0), 1);
        check_val("s1_ra_seen", 32'(ra_seen), 0);

        // Bounce shorter than the filter window.
        p0 = pulse_cnt;
        bus.pushButton = 1'b1; step(1);
        bus.pushButton = 1'b0; step(1);
        bus.pushButton = 1'b1; step(1);
        bus.pushButton = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            check_val("s2_bl", 32'(bus.buttonLevel), 0);
        end
        check_val("s2_npulse", 32'(pulse_cnt - p0), 0);

        // Hold-to-repeat: pulses at offsets 1, 11, 14, ..., 29 after the rise.
        bus.pushButton = 1'b1;
        step(6);
        check_val("s3_bl_rise", 32'(bus.buttonLevel), 1);
        for (int k = 1; k <= 30; k++) begin
            step(1);
            check_val($sformatf("s3_cp_off%0d", k), 32'(bus.countPulse),
                      32'((k == 1) || (k >= 11 && ((k - 11) % 3) == 0)));
            check_val($sformatf("s3_ra_off%0d", k), 32'(bus.repeatActive), 32'(k >= 11));
        end
        bus.pushButton = 1'b0;
        step(10);
        check_val("s3_bl_rel", 32'(bus.buttonLevel), 0);
        check_val("s3_ra_rel", 32'(bus.repeatActive), 0);

        // Clear switch while held.
        bus.pushButton = 1'b1;
        step(6);
        check_val("s4_bl_rise", 32'(bus.buttonLevel), 1);
        step(1);
        check_val("s4_cp_press", 32'(bus.countPulse), 1);
        bus.slideSwitch = 1'b1;
        step(5);
        check_val("s4_sl_early", 32'(bus.switchLevel), 0);
        step(1);
        check_val("s4_sl_rise", 32'(bus.switchLevel), 1);
        p0 = pulse_cnt;
        step(20);
        check_val("s4_npulse_clr", 32'(pulse_cnt - p0), 0);
        check_val("s4_ra_clr", 32'(bus.repeatActive), 0);
        bus.slideSwitch = 1'b0;
        step(5);
        check_val("s4_sl_hold", 32'(bus.switchLevel), 1);
        step(1);
        check_val("s4_sl_fall", 32'(bus.switchLevel), 0);
        step(20);
        check_val("s4_npulse_after", 32'(pulse_cnt - p0), 0);
        bus.pushButton = 1'b0;
        step(10);
        check_val("s4_bl_rel", 32'(bus.buttonLevel), 0);
        check_val("s4_npulse_rel", 32'(pulse_cnt - p0), 0);
        bus.pushButton = 1'b1;
        step(6);
        check_val("s4_bl_repress", 32'(bus.buttonLevel), 1);
        step(1);
        check_val("s4_cp_repress", 32'(bus.countPulse), 1);
        bus.pushButton = 1'b0;
        step(10);

        // Release lands on the HELD terminal-count cycle.
        bus.pushButton = 1'b1;
        step(6);
        check_val("s5_bl_rise", 32'(bus.buttonLevel), 1);
        step(1);
        check_val("s5_cp_press", 32'(bus.countPulse), 1);
        step(3);
        bus.pushButton = 1'b0;
        p0 = pulse_cnt;
        step(5);
        check_val("s5_bl_off9", 32'(bus.buttonLevel), 1);
        step(1);
        check_val("s5_bl_off10", 32'(bus.buttonLevel), 0);
        step(1);
        check_val("s5_cp_off11", 32'(bus.countPulse), 0);
        check_val("s5_ra_off11", 32'(bus.repeatActive), 0);
        step(5);
        check_val("s5_npulse", 32'(pulse_cnt - p0), 0);
        bus.pushButton = 1'b1;
        step(6);
        step(1);
        check_val("s5_cp_repress", 32'(bus.countPulse), 1);
        bus.pushButton = 1'b0;
        step(10);

        // Asynchronous reset in REPEATING with the button still held.
        bus.pushButton = 1'b1;
        step(6);
        step(12);
        check_val("s6_ra_pre", 32'(bus.repeatActive), 1);
        check_val("s6_bl_pre", 32'(bus.buttonLevel), 1);
        #2;
        reset = 1'b1;
        #1;
        check_val("s6_cp_async", 32'(bus.countPulse), 0);
        check_val("s6_bl_async", 32'(bus.buttonLevel), 0);
        check_val("s6_sl_async", 32'(bus.switchLevel), 0);
        check_val("s6_ra_async", 32'(bus.repeatActive), 0);
        step(2);
        check_val("s6_cp_inrst", 32'(bus.countPulse), 0);
        check_val("s6_bl_inrst", 32'(bus.buttonLevel), 0);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check_val($sformatf("s6_cp_e%0d", k), 32'(bus.countPulse), 32'(k == 7));
            check_val($sformatf("s6_bl_e%0d", k), 32'(bus.buttonLevel), 32'(k >= 6));
        end
        bus.pushButton = 1'b0;
        step(10);
        check_val("s6_bl_end", 32'(bus.buttonLevel), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_button_conditioner
`default_nettype wire
